// File: rtl/rec_pkg.sv
// Shared types and constants for the record/playback sequencer.
package rec_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      REC       = 3'd1,
      PLAY_RD   = 3'd2,
      PLAY_LAT  = 3'd3,
      PLAY_WAIT = 3'd4
   } state_t;

   localparam logic [1:0] MODE_IDLE = 2'b00;
   localparam logic [1:0] MODE_REC  = 2'b01;
   localparam logic [1:0] MODE_PLAY = 2'b10;

   // Display mode for a given sequencer state.
   function automatic logic [1:0] state_to_mode(input state_t s);
      logic [1:0] m;
      m = MODE_IDLE;
      case (s)
         REC:                         m = MODE_REC;
         PLAY_RD, PLAY_LAT, PLAY_WAIT: m = MODE_PLAY;
         default:                     m = MODE_IDLE;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/btn_edge.sv
// Registered rising-edge detector for a level button input. The history
// register resets to 0, so a button held through reset reads as a press on
// the first clock after release.
module btn_edge (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_i,
   output logic rise_o
);

   logic prev_q;

   // Remember last cycle's button level.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) prev_q <= 1'b0;
      else         prev_q <= btn_i;
   end

   assign rise_o = btn_i & ~prev_q;

endmodule

// File: rtl/rec_play_ctrl.sv
// Voice recorder sequencer: records deserialized words into one of two BRAM
// blocks and replays a stored block word by word into the serializer.
//
// Handshakes: donedes and doneser are single-cycle strobes from the
// deserializer/serializer and are never back-pressured; ser_load is a
// single-cycle strobe meaning ser_word is valid, and the next ser_load is
// only issued after the serializer has returned doneser for the current word.
module rec_play_ctrl
   import rec_pkg::*;
#(
   parameter int                ADDR_W   = 16,
   parameter int                DATA_W   = 16,
   parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}}
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              switch0,
   input  logic              record,
   input  logic              play,
   input  logic              donedes,
   input  logic [DATA_W-1:0] data,
   input  logic              doneser,
   input  logic [DATA_W-1:0] block1_dout,
   input  logic [DATA_W-1:0] block2_dout,
   output logic [ADDR_W-1:0] memaddr,
   output logic [DATA_W-1:0] memoryin,
   output logic              block1ena,
   output logic              block1wea,
   output logic              block2ena,
   output logic              block2wea,
   output logic              ser_load,
   output logic [DATA_W-1:0] ser_word,
   output logic              done,
   output logic [1:0]        mode,
   output logic [ADDR_W:0]   cur_len
);

   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                sel_q, sel_d;
   logic [ADDR_W:0]     len1_q, len1_d;
   logic [ADDR_W:0]     len2_q, len2_d;
   logic                wr_pend_q, wr_pend_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;
   logic [DATA_W-1:0]   ser_word_q, ser_word_d;
   logic                ser_load_q, ser_load_d;

   logic                rec_rise;
   logic                play_rise;
   logic                wr_en;
   logic                rd_en;
   logic                done_c;
   logic                rec_exit;
   logic [ADDR_W:0]     exit_len;
   logic [ADDR_W:0]     sel_len;
   logic [ADDR_W:0]     sw_len;
   logic [ADDR_W:0]     addr_plus_one;

   btn_edge u_rec_edge (
      .clk_i  (clock),
      .rst_ni (reset),
      .btn_i  (record),
      .rise_o (rec_rise)
   );

   btn_edge u_play_edge (
      .clk_i  (clock),
      .rst_ni (reset),
      .btn_i  (play),
      .rise_o (play_rise)
   );

   assign sel_len       = sel_q   ? len2_q : len1_q;
   assign sw_len        = switch0 ? len2_q : len1_q;
   assign addr_plus_one = {1'b0, addr_q} + LEN_ONE;

   // State, address, lengths and the registered write/serializer staging.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         sel_q      <= 1'b0;
         len1_q     <= '0;
         len2_q     <= '0;
         wr_pend_q  <= 1'b0;
         wr_data_q  <= '0;
         ser_word_q <= '0;
         ser_load_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         sel_q      <= sel_d;
         len1_q     <= len1_d;
         len2_q     <= len2_d;
         wr_pend_q  <= wr_pend_d;
         wr_data_q  <= wr_data_d;
         ser_word_q <= ser_word_d;
         ser_load_q <= ser_load_d;
      end
   end

   // Next-state logic: record writes one cycle after each donedes, playback
   // walks read -> latency -> wait-for-serializer per word.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      sel_d      = sel_q;
      len1_d     = len1_q;
      len2_d     = len2_q;
      wr_pend_d  = 1'b0;
      wr_data_d  = wr_data_q;
      ser_word_d = ser_word_q;
      ser_load_d = 1'b0;
      wr_en      = 1'b0;
      rd_en      = 1'b0;
      done_c     = 1'b0;
      rec_exit   = 1'b0;
      exit_len   = '0;

      case (state_q)
         IDLE: begin
            if (rec_rise) begin
               state_d = REC;
               addr_d  = '0;
               sel_d   = switch0;
            end else if (play_rise && (sw_len != '0)) begin
               state_d = PLAY_RD;
               addr_d  = '0;
               sel_d   = switch0;
            end
         end

         REC: begin
            if (wr_pend_q) begin
               wr_en  = 1'b1;
               addr_d = addr_q + ADDR_ONE;
            end
            // A full block ends the take regardless of the record level.
            // Otherwise a low record ends it, but a word arriving in that same
            // cycle is still written first (one more REC cycle).
            if (wr_pend_q && (addr_q == MAX_ADDR)) begin
               rec_exit = 1'b1;
               exit_len = addr_plus_one;
            end else if (!record && !donedes) begin
               rec_exit = 1'b1;
               exit_len = {1'b0, addr_q} + {{ADDR_W{1'b0}}, wr_pend_q};
            end
            if (rec_exit) begin
               state_d = IDLE;
               done_c  = 1'b1;
               if (sel_q) len2_d = exit_len;
               else       len1_d = exit_len;
            end else if (donedes) begin
               wr_pend_d = 1'b1;
               wr_data_d = data;
            end
         end

         PLAY_RD: begin
            rd_en   = 1'b1;
            state_d = record ? IDLE : PLAY_LAT;
         end

         PLAY_LAT: begin
            if (record) begin
               state_d = IDLE;
            end else begin
               ser_word_d = sel_q ? block2_dout : block1_dout;
               ser_load_d = 1'b1;
               state_d    = PLAY_WAIT;
            end
         end

         PLAY_WAIT: begin
            if (record) begin
               state_d = IDLE;
            end else if (doneser) begin
               addr_d = addr_q + ADDR_ONE;
               if (addr_plus_one == sel_len) begin
                  done_c  = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = PLAY_RD;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // Output decode: the enable belongs to the latched block only.
   always_comb begin
      block1ena = (wr_en | rd_en) & ~sel_q;
      block1wea = wr_en & ~sel_q;
      block2ena = (wr_en | rd_en) & sel_q;
      block2wea = wr_en & sel_q;
      memaddr   = addr_q;
      memoryin  = wr_data_q;
      ser_load  = ser_load_q;
      ser_word  = ser_word_q;
      done      = done_c;
      mode      = state_to_mode(state_q);
      cur_len   = (state_q == IDLE) ? sw_len : sel_len;
   end

endmodule

// File: tb/tb_rec_play_ctrl.sv
// Bench for rec_play_ctrl: directed scenarios plus a randomized loop, with a
// behavioural model of the two blocks (arrays + lengths) feeding expected
// queues that a negedge monitor drains.
module tb_rec_play_ctrl;

   localparam logic [1:0] M_IDLE = 2'b00;
   localparam logic [1:0] M_REC  = 2'b01;
   localparam logic [1:0] M_PLAY = 2'b10;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- main DUT ----------------
   logic        switch0 = 0, record = 0, play = 0, donedes = 0, doneser = 0;
   logic [15:0] data = 0;
   logic [15:0] b1_dout, b2_dout;
   logic [15:0] memaddr, memoryin, ser_word;
   logic        block1ena, block1wea, block2ena, block2wea, ser_load, done;
   logic [1:0]  mode;
   logic [16:0] cur_len;

   rec_play_ctrl dut (
      .clock(clk), .reset(rst_n), .switch0(switch0), .record(record),
      .play(play), .donedes(donedes), .data(data), .doneser(doneser),
      .block1_dout(b1_dout), .block2_dout(b2_dout), .memaddr(memaddr),
      .memoryin(memoryin), .block1ena(block1ena), .block1wea(block1wea),
      .block2ena(block2ena), .block2wea(block2wea), .ser_load(ser_load),
      .ser_word(ser_word), .done(done), .mode(mode), .cur_len(cur_len)
   );

   // BRAM fixtures, 1-cycle read latency
   logic [15:0] bram1 [0:255];
   logic [15:0] bram2 [0:255];
   always @(posedge clk) begin
      if (block1ena) begin
         if (block1wea) bram1[memaddr[7:0]] <= memoryin;
         b1_dout <= bram1[memaddr[7:0]];
      end
      if (block2ena) begin
         if (block2wea) bram2[memaddr[7:0]] <= memoryin;
         b2_dout <= bram2[memaddr[7:0]];
      end
   end

   // ---------------- small DUT (MAX_ADDR = 3) ----------------
   logic        s_record = 0, s_donedes = 0;
   logic [15:0] s_data = 0, s_zero = 0;
   logic [15:0] s_memaddr, s_memoryin, s_ser_word;
   logic        s_b1ena, s_b1wea, s_b2ena, s_b2wea, s_ser_load, s_done;
   logic [1:0]  s_mode;
   logic [16:0] s_cur_len;

   rec_play_ctrl #(.MAX_ADDR(16'd3)) dut_s (
      .clock(clk), .reset(rst_n), .switch0(1'b0), .record(s_record),
      .play(1'b0), .donedes(s_donedes), .data(s_data), .doneser(1'b0),
      .block1_dout(s_zero), .block2_dout(s_zero), .memaddr(s_memaddr),
      .memoryin(s_memoryin), .block1ena(s_b1ena), .block1wea(s_b1wea),
      .block2ena(s_b2ena), .block2wea(s_b2wea), .ser_load(s_ser_load),
      .ser_word(s_ser_word), .done(s_done), .mode(s_mode), .cur_len(s_cur_len)
   );

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;

   logic [32:0] exp_wr_q[$];    // {block, addr, data}
   logic [16:0] exp_rd_q[$];    // {block, addr}
   logic [15:0] exp_ser_q[$];
   logic [1:0]  exp_done_q[$];  // mode expected during the done pulse

   logic [15:0] model_mem [0:1][0:255];
   int          len_m [0:1];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: pops and compares on every observable DUT event.
   logic [32:0] obs_wr, e_wr;
   logic [16:0] obs_rd, e_rd;
   logic [15:0] e_ser;
   logic [1:0]  e_done;
   logic        ser_outstanding = 0;
   logic [15:0] s_wr_addr_q[$];
   int          s_done_cnt = 0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (block1ena && block2ena) begin
            checks++; errors++;
            $display("FAIL both_ena: got both enables high expected at most one");
         end
         if ((block1ena && block1wea) || (block2ena && block2wea)) begin
            obs_wr = {block2ena, memaddr, memoryin};
            checks++;
            if (exp_wr_q.size() == 0) begin
               errors++;
               $display("FAIL write: got 0x%0h expected no write", obs_wr);
            end else begin
               e_wr = exp_wr_q.pop_front();
               if (obs_wr !== e_wr) begin
                  errors++;
                  $display("FAIL write: got 0x%0h expected 0x%0h", obs_wr, e_wr);
               end
            end
         end
         if ((block1ena && !block1wea) || (block2ena && !block2wea)) begin
            obs_rd = {block2ena, memaddr};
            checks++;
            if (exp_rd_q.size() == 0) begin
               errors++;
               $display("FAIL read: got 0x%0h expected no read", obs_rd);
            end else begin
               e_rd = exp_rd_q.pop_front();
               if (obs_rd !== e_rd) begin
                  errors++;
                  $display("FAIL read: got 0x%0h expected 0x%0h", obs_rd, e_rd);
               end
            end
         end
         if (ser_load) begin
            checks++;
            if (ser_outstanding) begin
               errors++;
               $display("FAIL ser_order: got load before doneser expected doneser first");
            end
            ser_outstanding = 1'b1;
            checks++;
            if (exp_ser_q.size() == 0) begin
               errors++;
               $display("FAIL ser_word: got 0x%0h expected no load", ser_word);
            end else begin
               e_ser = exp_ser_q.pop_front();
               if (ser_word !== e_ser) begin
                  errors++;
                  $display("FAIL ser_word: got 0x%0h expected 0x%0h", ser_word, e_ser);
               end
            end
         end
         if (doneser) ser_outstanding = 1'b0;
         if (mode == M_IDLE) ser_outstanding = 1'b0;
         if (done) begin
            checks++;
            if (exp_done_q.size() == 0) begin
               errors++;
               $display("FAIL done: got pulse in mode %0d expected none", mode);
            end else begin
               e_done = exp_done_q.pop_front();
               if (mode !== e_done) begin
                  errors++;
                  $display("FAIL done_mode: got %0d expected %0d", mode, e_done);
               end
            end
         end
         if (s_b1ena && s_b1wea) s_wr_addr_q.push_back(s_memaddr);
         if (s_done) s_done_cnt++;
      end else begin
         ser_outstanding = 1'b0;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_idle(input string name);
      int k;
      for (k = 0; k < 40; k++) begin
         if (mode == M_IDLE) break;
         tick(1);
      end
      check(name, {62'd0, mode}, {62'd0, M_IDLE});
   endtask

   task automatic wait_ser_load(output bit ok);
      ok = 0;
      for (int k = 0; k < 40; k++) begin
         if (ser_load) begin
            ok = 1;
            break;
         end
         tick(1);
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL ser_load_timeout: got no load expected a load within 40 cycles");
      end
   endtask

   // Record n words into block sel. drop: record falls with the last donedes.
   task automatic do_record(input bit sel, input int n, input bit fixed,
                            input bit drop, input bit with_play);
      logic [15:0] w;
      switch0 = sel;
      record  = 1;
      play    = with_play;
      tick(1);
      play = 0;
      check("rec_entry_mode", {62'd0, mode}, {62'd0, M_REC});
      for (int i = 0; i < n; i++) begin
         tick($urandom_range(0, 3));
         w = fixed ? 16'(16'h1111 * (i + 1)) : 16'($urandom);
         data    = w;
         donedes = 1;
         exp_wr_q.push_back({sel, 16'(i), w});
         model_mem[sel][i] = w;
         if (drop && i == n - 1) record = 0;
         tick(1);
         donedes = 0;
      end
      len_m[sel] = n;
      exp_done_q.push_back(M_REC);
      record = 0;
      wait_idle("rec_return_idle");
      tick(1);
      check("rec_cur_len", 64'(cur_len), 64'(len_m[switch0]));
   endtask

   // Play block sel through to completion (or expect nothing if empty).
   task automatic do_play(input bit sel);
      bit ok;
      switch0 = sel;
      if (len_m[sel] == 0) begin
         play = 1;
         tick(1);
         play = 0;
         tick(5);
         check("play_empty_idle", {62'd0, mode}, {62'd0, M_IDLE});
         return;
      end
      for (int i = 0; i < len_m[sel]; i++) begin
         exp_rd_q.push_back({sel, 16'(i)});
         exp_ser_q.push_back(model_mem[sel][i]);
      end
      exp_done_q.push_back(M_PLAY);
      play = 1;
      tick(1);
      play = 0;
      for (int i = 0; i < len_m[sel]; i++) begin
         wait_ser_load(ok);
         if (!ok) break;
         tick($urandom_range(0, 4));
         doneser = 1;
         tick(1);
         doneser = 0;
      end
      wait_idle("play_return_idle");
      check("play_cur_len", 64'(cur_len), 64'(len_m[switch0]));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      bit ok;
      len_m[0] = 0;
      len_m[1] = 0;

      // 1. reset held with record high; outputs quiet during reset
      switch0 = 0;
      record  = 1;
      tick(3);
      check("rst_mode", {62'd0, mode}, 64'd0);
      check("rst_ena", {60'd0, block1ena, block1wea, block2ena, block2wea}, 64'd0);
      check("rst_done_load", {62'd0, done, ser_load}, 64'd0);
      check("rst_cur_len", 64'(cur_len), 64'd0);
      check("rst_memaddr", 64'(memaddr), 64'd0);
      check("rst_ser_word", 64'(ser_word), 64'd0);
      rst_n = 1;
      tick(1);
      check("rec_after_reset", {62'd0, mode}, {62'd0, M_REC});
      // zero-word take still pulses done
      exp_done_q.push_back(M_REC);
      record = 0;
      wait_idle("zero_rec_idle");
      check("zero_rec_len", 64'(cur_len), 64'd0);

      // 2. four fixed words into block1
      do_record(0, 4, 1, 0, 0);
      check("blk1_len4", 64'(cur_len), 64'd4);

      // 3. replay block1
      do_play(0);

      // 4. empty block2 play, then simultaneous record+play edges
      do_play(1);
      do_record(1, 3, 0, 1, 1);
      do_play(1);
      switch0 = 0;
      tick(1);
      check("cur_len_follows_sw", 64'(cur_len), 64'd4);

      // 5. small build: block full after 4 words while record stays high
      s_record = 1;
      tick(1);
      for (int i = 0; i < 6; i++) begin
         s_data    = 16'(16'hA000 + i);
         s_donedes = 1;
         tick(1);
         s_donedes = 0;
         tick(1);
      end
      tick(3);
      check("full_write_count", 64'(s_wr_addr_q.size()), 64'd4);
      for (int i = 0; i < 4 && i < s_wr_addr_q.size(); i++)
         check("full_write_addr", 64'(s_wr_addr_q[i]), 64'(i));
      check("full_done_count", 64'(s_done_cnt), 64'd1);
      check("full_mode_idle", {62'd0, s_mode}, {62'd0, M_IDLE});
      check("full_len", 64'(s_cur_len), 64'd4);
      s_record = 0;
      tick(2);

      // 6a. record during PLAY_WAIT aborts without done and without REC
      switch0 = 0;
      exp_rd_q.push_back({1'b0, 16'd0});
      exp_ser_q.push_back(model_mem[0][0]);
      play = 1;
      tick(1);
      play = 0;
      wait_ser_load(ok);
      record = 1;
      tick(1);
      check("abort_idle", {62'd0, mode}, {62'd0, M_IDLE});
      tick(3);
      check("abort_no_rec", {62'd0, mode}, {62'd0, M_IDLE});
      record = 0;
      tick(2);
      check("abort_len_kept", 64'(cur_len), 64'd4);

      // 6b. async reset mid-REC clears everything at once
      switch0 = 1;
      record  = 1;
      tick(1);
      check("rec2_mode", {62'd0, mode}, {62'd0, M_REC});
      data    = 16'hBEEF;
      donedes = 1;
      exp_wr_q.push_back({1'b1, 16'd0, 16'hBEEF});
      tick(1);
      donedes = 0;
      tick(2);
      #2;
      rst_n = 0;
      #1;
      check("arst_mode", {62'd0, mode}, 64'd0);
      check("arst_ena", {60'd0, block1ena, block1wea, block2ena, block2wea}, 64'd0);
      check("arst_memaddr", 64'(memaddr), 64'd0);
      check("arst_cur_len", 64'(cur_len), 64'd0);
      len_m[0] = 0;
      len_m[1] = 0;
      record = 0;
      tick(2);
      rst_n = 1;
      tick(2);
      switch0 = 0;
      tick(1);
      check("arst_len_lost", 64'(cur_len), 64'd0);

      // randomized record/play rounds
      for (int r = 0; r < 8; r++) begin
         bit s;
         s = 1'($urandom_range(0, 1));
         do_record(s, $urandom_range(0, 8), 0, 1'($urandom_range(0, 1)), 0);
         do_play(s);
         do_play(1'($urandom_range(0, 1)));
      end

      tick(5);
      check("exp_wr_drained", 64'(exp_wr_q.size()), 64'd0);
      check("exp_rd_drained", 64'(exp_rd_q.size()), 64'd0);
      check("exp_ser_drained", 64'(exp_ser_q.size()), 64'd0);
      check("exp_done_drained", 64'(exp_done_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #1000000;
      $display("FAIL watchdog: got no completion expected finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
